// File: rtl/rom_dump_sequencer.sv
// Sweeps a 556PT5/556PT4 ROM over an inclusive, wrapping address range and
// streams each captured word to a valid/ready sink.
module rom_dump_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 9,
    parameter int ACCESS_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ADDRESS_WIDTH-1:0] start_address,
    input  logic [ADDRESS_WIDTH-1:0] end_address,
    input  logic [DATA_WIDTH-1:0]    data_line_in,
    output logic [3:0]               operation,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [ADDRESS_WIDTH-1:0] out_address,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [3:0] OP_IDLE = 4'b0000;
    localparam logic [3:0] OP_READ = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t                   state_q;
    logic [3:0]               op_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [ADDRESS_WIDTH-1:0] end_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [ADDRESS_WIDTH-1:0] out_addr_q;
    logic                     valid_q;
    logic                     busy_q;
    logic                     done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_IDLE;
            addr_q     <= '0;
            end_q      <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            out_addr_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // abort outranks start so a held abort keeps the socket quiet
                    if (start && !abort) begin
                        addr_q  <= start_address;
                        end_q   <= end_address;
                        op_q    <= OP_READ;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (abort) begin
                        op_q    <= OP_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        data_q     <= data_line_in;
                        out_addr_q <= addr_q;
                        valid_q    <= 1'b1;
                        state_q    <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (abort) begin
                        op_q    <= OP_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (out_ready) begin
                        valid_q <= 1'b0;
                        if (addr_q == end_q) begin
                            op_q    <= OP_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            addr_q  <= addr_q + ADDRESS_WIDTH'(1);
                            cnt_q   <= CNT_INIT;
                            state_q <= ST_WAIT;
                        end
                    end
                end
                default: begin
                    op_q    <= OP_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign operation    = op_q;
    assign address_line = addr_q;
    assign out_data     = data_q;
    assign out_address  = out_addr_q;
    assign out_valid    = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_rom_dump_sequencer.sv
// Directed bench for rom_dump_sequencer: a 3604-sized instance (access 4) and
// a 3601-sized instance (access 1), each fed by a combinational ROM model.
module tb_rom_dump_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, abort, out_ready;
    logic [8:0] start_address, end_address;
    bit         use_b;

    logic [3:0] a_op;
    logic [8:0] a_aline, a_oaddr;
    logic [7:0] a_odata, a_din;
    logic       a_valid, a_busy, a_done;

    logic [3:0] b_op;
    logic [7:0] b_aline, b_oaddr;
    logic [3:0] b_odata, b_din;
    logic       b_valid, b_busy, b_done;

    assign a_din = a_aline[7:0] ^ 8'hA5;
    assign b_din = b_aline[3:0] ^ 4'h5;

    rom_dump_sequencer #(.DATA_WIDTH(8), .ADDRESS_WIDTH(9), .ACCESS_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset), .start(start & ~use_b), .abort(abort),
        .start_address(start_address), .end_address(end_address),
        .data_line_in(a_din), .operation(a_op), .address_line(a_aline),
        .out_data(a_odata), .out_address(a_oaddr), .out_valid(a_valid),
        .out_ready(out_ready), .busy(a_busy), .done(a_done)
    );

    rom_dump_sequencer #(.DATA_WIDTH(4), .ADDRESS_WIDTH(8), .ACCESS_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .start(start & use_b), .abort(abort),
        .start_address(start_address[7:0]), .end_address(end_address[7:0]),
        .data_line_in(b_din), .operation(b_op), .address_line(b_aline),
        .out_data(b_odata), .out_address(b_oaddr), .out_valid(b_valid),
        .out_ready(out_ready), .busy(b_busy), .done(b_done)
    );

    logic [3:0] cur_op;
    logic [8:0] cur_aline, cur_oaddr;
    logic [7:0] cur_odata;
    logic       cur_valid, cur_busy, cur_done;

    always_comb begin
        cur_op    = a_op;
        cur_aline = a_aline;
        cur_oaddr = a_oaddr;
        cur_odata = a_odata;
        cur_valid = a_valid;
        cur_busy  = a_busy;
        cur_done  = a_done;
        if (use_b) begin
            cur_op    = b_op;
            cur_aline = {1'b0, b_aline};
            cur_oaddr = {1'b0, b_oaddr};
            cur_odata = {4'h0, b_odata};
            cur_valid = b_valid;
            cur_busy  = b_busy;
            cur_done  = b_done;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_data(input int addr);
        if (use_b) return (addr & 15) ^ 5;
        return (addr & 255) ^ 'hA5;
    endfunction

    // ready tied high; poke_t >= 0 pulses start with a different range mid-dump
    task automatic run_dump(input int sa, input int ea, input int n, input int poke_t);
        int acc   = use_b ? 1 : 4;
        int per   = acc + 1;
        int msk   = use_b ? 255 : 511;
        int words = 0;
        int t     = 0;
        int exp_a;
        bit fin   = 0;
        start_address = 9'(sa);
        end_address   = 9'(ea);
        out_ready     = 1'b1;
        start         = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(cur_busy), 1);
        chk("start_op", 32'(cur_op), 32'hC);
        chk("start_aline", 32'(cur_aline), sa);
        while (!fin && t < n * per + 20) begin
            if (t == poke_t) begin
                start         = 1'b1;
                start_address = 9'((sa + 7) & msk);
                end_address   = 9'((sa + 9) & msk);
            end
            tick();
            t++;
            start = 1'b0;
            if (cur_valid) begin
                exp_a = (sa + words) & msk;
                chk("word_addr", 32'(cur_oaddr), exp_a);
                chk("word_data", 32'(cur_odata), exp_data(exp_a));
                chk("word_aline", 32'(cur_aline), exp_a);
                chk("word_time", t, acc + per * words);
                words++;
            end
            if (cur_done) begin
                chk("done_time", t, n * per);
                chk("done_busy", 32'(cur_busy), 0);
                chk("done_op", 32'(cur_op), 0);
                fin = 1;
            end else if (t < n * per) begin
                chk("run_op", 32'(cur_op), 32'hC);
            end
        end
        chk("word_count", words, n);
        chk("finished", 32'(fin), 1);
        tick();
        chk("done_pulse", 32'(cur_done), 0);
        chk("idle_busy", 32'(cur_busy), 0);
    endtask

    initial begin
        int nwords;
        bit extra;
        use_b = 0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        start_address = '0; end_address = '0;
        tick();
        tick();
        chk("rst_op", 32'(a_op), 0);
        chk("rst_aline", 32'(a_aline), 0);
        chk("rst_odata", 32'(a_odata), 0);
        chk("rst_oaddr", 32'(a_oaddr), 0);
        chk("rst_valid", 32'(a_valid), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_b_busy", 32'(b_busy), 0);
        reset = 1'b0;
        tick();

        run_dump('h010, 'h013, 4, -1);
        run_dump('h1FE, 'h001, 4, -1);
        run_dump('h055, 'h055, 1, 2);

        // backpressure
        start_address = 9'h020; end_address = 9'h021; out_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        chk("bp_valid", 32'(a_valid), 1);
        chk("bp_data", 32'(a_odata), 32'h85);
        chk("bp_addr", 32'(a_oaddr), 32'h020);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid", 32'(a_valid), 1);
            chk("bp_hold_data", 32'(a_odata), 32'h85);
            chk("bp_hold_addr", 32'(a_oaddr), 32'h020);
            chk("bp_hold_aline", 32'(a_aline), 32'h020);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_hs_valid", 32'(a_valid), 0);
        chk("bp_hs_aline", 32'(a_aline), 32'h021);
        chk("bp_hs_busy", 32'(a_busy), 1);
        repeat (4) tick();
        chk("bp2_valid", 32'(a_valid), 1);
        chk("bp2_data", 32'(a_odata), 32'h84);
        chk("bp2_addr", 32'(a_oaddr), 32'h021);
        tick();
        chk("bp_done", 32'(a_done), 1);
        chk("bp_done_busy", 32'(a_busy), 0);
        tick();

        // abort during WAIT of the third word
        start_address = 9'h030; end_address = 9'h03F; out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        nwords = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (a_valid) nwords++;
        end
        chk("ab_words_before", nwords, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", 32'(a_busy), 0);
        chk("ab_op", 32'(a_op), 0);
        chk("ab_valid", 32'(a_valid), 0);
        chk("ab_done", 32'(a_done), 0);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (a_valid || a_done || a_busy) extra = 1;
        end
        chk("ab_quiet", 32'(extra), 0);

        // reset mid-dump
        start_address = 9'h040; end_address = 9'h04F; out_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        chk("mr_pre_valid", 32'(a_valid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_op", 32'(a_op), 0);
        chk("mr_aline", 32'(a_aline), 0);
        chk("mr_odata", 32'(a_odata), 0);
        chk("mr_oaddr", 32'(a_oaddr), 0);
        chk("mr_valid", 32'(a_valid), 0);
        chk("mr_busy", 32'(a_busy), 0);
        chk("mr_done", 32'(a_done), 0);
        out_ready = 1'b1;

        // start and abort together in IDLE
        start_address = 9'h010; end_address = 9'h011;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", 32'(a_busy), 0);
        chk("sa_op", 32'(a_op), 0);
        tick();
        chk("sa_busy2", 32'(a_busy), 0);

        // 3601 geometry, full 256-word sweep
        use_b = 1;
        run_dump('h00, 'hFF, 256, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
